multi_channel_pausable_clock: RTL and testbench
===============================================

# multi_channel_pausable_clock

Parametrised N-channel derived-clock generator, successor to the single-channel pausable generator in the clks_alot generation tree. Each channel divides the system clock by its own programmable half period. Each channel runs a free-running "ghost" phase and a glitch-free pausable output that parks at a chosen polarity and rejoins the ghost phase-aligned. Outputs feed the event/IO stages as registered clocks with preemptive edge strobes and status.

## Interface
Parameters:
- CHANNELS, 4: number of independent channels (≥1).
- RATE_WIDTH, clks_alot_p::RATE_COUNTER_WIDTH: half-period and pause-duration counter width.

Ports:
- clk_i  in  1  system clock.
- async_rst_i  in  1  reset, asynchronous, active-high.
- clk_en_i  in  1  global clock enable; counters, init and state advance only when high.
- init_i  in  1  synchronous restart of all channels (qualified by clk_en_i).
- ch_en_i  in  CHANNELS  per-channel generation enable.
- half_period_i  in  CHANNELS×RATE_WIDTH  system cycles per half period; 0 treated as 1.
- starting_polarity_i  in  CHANNELS  level after reset, init or enable.
- pause_en_i  in  CHANNELS  pause request.
- pause_polarity_i  in  CHANNELS  level held while paused.
- clk_o  out  CHANNELS  pausable clock (registered).
- ghost_clk_o  out  CHANNELS  unpausable clock (registered).
- rise_o / fall_o  out  CHANNELS each  preemptive strobe: clk_o rises/falls on the next clk_i edge.
- pause_active_o  out  CHANNELS  channel in PAUSED.
- pause_duration_o  out  CHANNELS×RATE_WIDTH  suppressed ghost toggles in current/last pause, saturating.
- locked_o  out  CHANNELS  stable period achieved.

## Operation
- Per channel: counter cnt, shadow period hp (latched from half_period_i at enable, init and each toggle), ghost bit, out bit, state.
- Toggle event tog = clk_en_i && state≠IDLE && cnt==hp−1; on tog cnt←0, ghost←~ghost, hp reloads; else cnt+1 when clk_en_i. Period changes take effect only at the next toggle.
- States:
  - IDLE: ch_en_i=0; cnt=0, ghost=out=starting_polarity. ch_en_i=1 → RUN.
  - RUN: out follows ghost. pause_en_i=1: ghost==pause_polarity → PAUSED; otherwise → PAUSE_PEND.
  - PAUSE_PEND: out follows ghost. The tog that moves ghost to pause_polarity → PAUSED. pause_en_i dropping → RUN.
  - PAUSED: out held at pause_polarity; pause_duration +1 per tog (saturating at all-ones), cleared on entry. Exit to RUN once pause_en_i=0 and ghost==pause_polarity. If ghost≠pause_polarity, wait for the tog that lands on it.
- Any state with ch_en_i=0 → IDLE next cycle; clk_o forced to starting_polarity (permitted runt edge, documented).
- init_i (with clk_en_i): every channel cnt=0, ghost=out=starting_polarity, hp reloaded, pause_duration=0. State becomes RUN if ch_en_i, else IDLE. init takes priority over tog and pause.
- locked_o: set on the second tog after enable/init. Cleared by init, disable, or half_period_i≠hp sampled at a toggle.
- pause_polarity_i is sampled at PAUSED entry and held until exit.

## Timing
- Reset values: clk_o=ghost_clk_o=starting_polarity_i (sampled combinationally during reset), rise_o=fall_o=0, pause_active_o=0, pause_duration_o=0, locked_o=0, state IDLE.
- After ch_en_i rises at cycle t (clk_en_i constant 1), the first ghost toggle lands at the t+1+hp edge. Output period = 2·hp clk_en_i-qualified cycles.
- rise_o/fall_o assert in the cycle before clk_o changes, exactly one cycle wide. No strobe fires for suppressed toggles.
- pause_active_o rises in the same cycle as the PAUSED state register.
- Channels are independent. Identical hp and polarity after init keep them edge-aligned indefinitely.

## Structure
- clks_alot_p gains: channel_state_e {IDLE, RUN, PAUSE_PEND, PAUSED}, and per-channel status struct {pause_active, pause_duration, locked}. RATE_COUNTER_WIDTH stays there.
- Sub-module pausable_clock_channel holds one channel's FSM, counter and status. The top generates CHANNELS instances and broadcasts clk_en_i and init_i.

## Test plan
- Reset, then ch_en=1, hp=3, start=0 → ghost/clk_o rise at 4 cycles after enable, then toggle every 3 cycles; rise_o one cycle earlier each time.
- hp=2, pause_en set while clk_o=1, pause_pol=0 → clk_o falls on schedule then holds 0. After 4 suppressed toggles pause_duration=4. Release → clk_o rises only at a ghost rising toggle, no runt.
- pause_en set while ghost==pause_pol=1 → PAUSED same cycle +1, no edge.
- CH=4, hp {1,2,3,4}, init pulse → all four outputs = starting polarities next cycle; counts restart from 0.
- hp changed 3→5 mid-half-period → current half stays 3, next halves 5; locked_o drops, re-asserts after 2 toggles.
- clk_en_i low for 10 cycles mid-run → no toggles/strobes; resumes with cnt preserved. async_rst_i mid-pause → all outputs at reset values immediately.

Source files
------------

// File: rtl/multi_channel_pausable_clock_pkg.sv
// Shared types and widths for the multi-channel pausable clock generator.
package multi_channel_pausable_clock_pkg;

  localparam int RATE_COUNTER_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN        = 2'd1,
    PAUSE_PEND = 2'd2,
    PAUSED     = 2'd3
  } channel_state_e;

  typedef struct packed {
    logic                          pause_active;
    logic [RATE_COUNTER_WIDTH-1:0] pause_duration;
    logic                          locked;
  } channel_status_t;

endpackage

// File: rtl/multi_channel_pausable_clock_if.sv
// Control and status bundle between the clock generator and its user.
interface multi_channel_pausable_clock_if
  import multi_channel_pausable_clock_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int RATE_WIDTH = RATE_COUNTER_WIDTH
);
  logic                           clk_en_i;
  logic                           init_i;
  logic [CHANNELS-1:0]            ch_en_i;
  logic [CHANNELS*RATE_WIDTH-1:0] half_period_i;
  logic [CHANNELS-1:0]            starting_polarity_i;
  logic [CHANNELS-1:0]            pause_en_i;
  logic [CHANNELS-1:0]            pause_polarity_i;
  logic [CHANNELS-1:0]            clk_o;
  logic [CHANNELS-1:0]            ghost_clk_o;
  logic [CHANNELS-1:0]            rise_o;
  logic [CHANNELS-1:0]            fall_o;
  logic [CHANNELS-1:0]            pause_active_o;
  logic [CHANNELS*RATE_WIDTH-1:0] pause_duration_o;
  logic [CHANNELS-1:0]            locked_o;

  modport master (
    output clk_en_i, init_i, ch_en_i, half_period_i, starting_polarity_i,
           pause_en_i, pause_polarity_i,
    input  clk_o, ghost_clk_o, rise_o, fall_o, pause_active_o,
           pause_duration_o, locked_o
  );

  modport slave (
    input  clk_en_i, init_i, ch_en_i, half_period_i, starting_polarity_i,
           pause_en_i, pause_polarity_i,
    output clk_o, ghost_clk_o, rise_o, fall_o, pause_active_o,
           pause_duration_o, locked_o
  );
endinterface

// File: rtl/multi_channel_pausable_clock_channel.sv
// One derived-clock channel: free-running ghost phase plus a glitch-free
// pausable output that parks at a chosen level and rejoins phase-aligned.
module multi_channel_pausable_clock_channel
  import multi_channel_pausable_clock_pkg::*;
#(
  parameter int RATE_WIDTH = RATE_COUNTER_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  clk_en_i,
  input  logic                  init_i,
  input  logic                  ch_en_i,
  input  logic [RATE_WIDTH-1:0] half_period_i,
  input  logic                  starting_polarity_i,
  input  logic                  pause_en_i,
  input  logic                  pause_polarity_i,
  output logic                  clk_o,
  output logic                  ghost_clk_o,
  output logic                  rise_o,
  output logic                  fall_o,
  output logic                  pause_active_o,
  output logic [RATE_WIDTH-1:0] pause_duration_o,
  output logic                  locked_o
);

  channel_state_e        state, state_nxt;
  logic [RATE_WIDTH-1:0] cnt, cnt_nxt, hp, hp_nxt, dur, dur_nxt, hp_last;
  logic ghost, ghost_nxt, out, out_nxt, pol_q, pol_nxt;
  logic locked, locked_nxt, lock_seen, lock_seen_nxt;
  logic tog;

  // A programmed half period of 0 behaves as 1.
  assign hp_last = (hp == '0) ? '0 : hp - RATE_WIDTH'(1);
  assign tog     = clk_en_i && (state != IDLE) && (cnt == hp_last);

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      hp        <= '0;
      dur       <= '0;
      ghost     <= starting_polarity_i;
      out       <= starting_polarity_i;
      pol_q     <= 1'b0;
      locked    <= 1'b0;
      lock_seen <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hp        <= hp_nxt;
      dur       <= dur_nxt;
      ghost     <= ghost_nxt;
      out       <= out_nxt;
      pol_q     <= pol_nxt;
      locked    <= locked_nxt;
      lock_seen <= lock_seen_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hp_nxt        = hp;
    dur_nxt       = dur;
    ghost_nxt     = ghost;
    out_nxt       = out;
    pol_nxt       = pol_q;
    locked_nxt    = locked;
    lock_seen_nxt = lock_seen;
    if (clk_en_i) begin
      if (init_i || !ch_en_i || state == IDLE) begin
        cnt_nxt       = '0;
        hp_nxt        = half_period_i;
        ghost_nxt     = starting_polarity_i;
        out_nxt       = starting_polarity_i;
        locked_nxt    = 1'b0;
        lock_seen_nxt = 1'b0;
        state_nxt     = ch_en_i ? RUN : IDLE;
        if (init_i) dur_nxt = '0;
      end else begin
        if (tog) begin
          cnt_nxt   = '0;
          ghost_nxt = ~ghost;
          hp_nxt    = half_period_i;
          // Lock needs two consecutive toggles with an unchanged period.
          if (half_period_i != hp) begin
            locked_nxt    = 1'b0;
            lock_seen_nxt = 1'b0;
          end else begin
            locked_nxt    = locked | lock_seen;
            lock_seen_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + RATE_WIDTH'(1);
        end
        case (state)
          RUN: begin
            out_nxt = ghost_nxt;
            if (pause_en_i) begin
              if (ghost == pause_polarity_i) begin
                state_nxt = PAUSED;
                pol_nxt   = pause_polarity_i;
                out_nxt   = pause_polarity_i;
                dur_nxt   = '0;
              end else begin
                state_nxt = PAUSE_PEND;
              end
            end
          end
          PAUSE_PEND: begin
            out_nxt = ghost_nxt;
            if (!pause_en_i) begin
              state_nxt = RUN;
            end else if (ghost_nxt == pause_polarity_i) begin
              state_nxt = PAUSED;
              pol_nxt   = pause_polarity_i;
              dur_nxt   = '0;
            end
          end
          PAUSED: begin
            out_nxt = pol_q;
            if (tog && dur != '1) dur_nxt = dur + RATE_WIDTH'(1);
            // Rejoin only while ghost sits at the parked level: no runt pulse.
            if (!pause_en_i && ghost == pol_q) begin
              state_nxt = RUN;
              out_nxt   = ghost_nxt;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  assign clk_o            = async_rst_i ? starting_polarity_i : out;
  assign ghost_clk_o      = async_rst_i ? starting_polarity_i : ghost;
  assign rise_o           = !async_rst_i && !out && out_nxt;
  assign fall_o           = !async_rst_i && out && !out_nxt;
  assign pause_active_o   = (state == PAUSED);
  assign pause_duration_o = dur;
  assign locked_o         = locked;

endmodule

// File: rtl/multi_channel_pausable_clock.sv
// N-channel pausable clock generator; clk_en and init are shared by all channels.
module multi_channel_pausable_clock
  import multi_channel_pausable_clock_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int RATE_WIDTH = RATE_COUNTER_WIDTH
) (
  input logic                          clk_i,
  input logic                          async_rst_i,
  multi_channel_pausable_clock_if.slave bus
);

  logic [CHANNELS-1:0]            clk_v, ghost_v, rise_v, fall_v, active_v, locked_v;
  logic [CHANNELS*RATE_WIDTH-1:0] dur_v;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    multi_channel_pausable_clock_channel #(
      .RATE_WIDTH(RATE_WIDTH)
    ) u_ch (
      .clk_i              (clk_i),
      .async_rst_i        (async_rst_i),
      .clk_en_i           (bus.clk_en_i),
      .init_i             (bus.init_i),
      .ch_en_i            (bus.ch_en_i[i]),
      .half_period_i      (bus.half_period_i[i*RATE_WIDTH +: RATE_WIDTH]),
      .starting_polarity_i(bus.starting_polarity_i[i]),
      .pause_en_i         (bus.pause_en_i[i]),
      .pause_polarity_i   (bus.pause_polarity_i[i]),
      .clk_o              (clk_v[i]),
      .ghost_clk_o        (ghost_v[i]),
      .rise_o             (rise_v[i]),
      .fall_o             (fall_v[i]),
      .pause_active_o     (active_v[i]),
      .pause_duration_o   (dur_v[i*RATE_WIDTH +: RATE_WIDTH]),
      .locked_o           (locked_v[i])
    );
  end

  assign bus.clk_o            = clk_v;
  assign bus.ghost_clk_o      = ghost_v;
  assign bus.rise_o           = rise_v;
  assign bus.fall_o           = fall_v;
  assign bus.pause_active_o   = active_v;
  assign bus.pause_duration_o = dur_v;
  assign bus.locked_o         = locked_v;

endmodule

// File: tb/tb_multi_channel_pausable_clock.sv
// Directed bench for the multi-channel pausable clock generator.
module tb_multi_channel_pausable_clock;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multi_channel_pausable_clock_if #(.CHANNELS(4), .RATE_WIDTH(8)) bus ();

  multi_channel_pausable_clock #(.CHANNELS(4), .RATE_WIDTH(8)) dut (
    .clk_i      (clk),
    .async_rst_i(rst),
    .bus        (bus.slave)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.clk_en_i            = 1'b1;
    bus.init_i              = 1'b0;
    bus.ch_en_i             = 4'b0000;
    bus.half_period_i       = {8'd3, 8'd3, 8'd3, 8'd3};
    bus.starting_polarity_i = 4'b1010;
    bus.pause_en_i          = 4'b0000;
    bus.pause_polarity_i    = 4'b0000;
    #12;
    chk("rst_clk",    32'(bus.clk_o), 32'hA);
    chk("rst_ghost",  32'(bus.ghost_clk_o), 32'hA);
    chk("rst_rise",   32'(bus.rise_o), 0);
    chk("rst_fall",   32'(bus.fall_o), 0);
    chk("rst_active", 32'(bus.pause_active_o), 0);
    chk("rst_dur",    bus.pause_duration_o, 0);
    chk("rst_locked", 32'(bus.locked_o), 0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);

    // enable ch0, hp=3, start=0 (edge e0 just passed)
    bus.ch_en_i = 4'b0001;
    tick(1);
    chk("en_c1_clk", 32'(bus.clk_o[0]), 0);
    tick(2);
    chk("en_c3_rise", 32'(bus.rise_o[0]), 1);
    chk("en_c3_clk",  32'(bus.clk_o[0]), 0);
    tick(1);
    chk("en_c4_clk",    32'(bus.clk_o[0]), 1);
    chk("en_c4_ghost",  32'(bus.ghost_clk_o[0]), 1);
    chk("en_c4_rise",   32'(bus.rise_o[0]), 0);
    chk("en_c4_locked", 32'(bus.locked_o[0]), 0);
    tick(2);
    chk("en_c6_fall", 32'(bus.fall_o[0]), 1);
    tick(1);
    chk("en_c7_clk",    32'(bus.clk_o[0]), 0);
    chk("en_c7_locked", 32'(bus.locked_o[0]), 1);

    // hp=2 with init, then pause at level 0 while clk_o is high (edge I)
    bus.half_period_i[7:0] = 8'd2;
    bus.init_i = 1'b1;
    tick(1);
    bus.init_i = 1'b0;
    chk("init_clk",    32'(bus.clk_o), 32'hA);
    chk("init_locked", 32'(bus.locked_o[0]), 0);
    tick(2);
    chk("p_i2_clk", 32'(bus.clk_o[0]), 1);
    bus.pause_en_i = 4'b0001;
    tick(1);
    chk("p_i3_active", 32'(bus.pause_active_o[0]), 0);
    chk("p_i3_fall",   32'(bus.fall_o[0]), 1);
    tick(1);
    chk("p_i4_clk",    32'(bus.clk_o[0]), 0);
    chk("p_i4_active", 32'(bus.pause_active_o[0]), 1);
    chk("p_i4_dur",    32'(bus.pause_duration_o[7:0]), 0);
    tick(1);
    chk("p_i5_rise", 32'(bus.rise_o[0]), 0);
    tick(1);
    chk("p_i6_ghost", 32'(bus.ghost_clk_o[0]), 1);
    chk("p_i6_clk",   32'(bus.clk_o[0]), 0);
    chk("p_i6_dur",   32'(bus.pause_duration_o[7:0]), 1);
    tick(4);
    chk("p_i10_dur", 32'(bus.pause_duration_o[7:0]), 3);
    bus.pause_en_i = 4'b0000;
    tick(1);
    chk("p_i11_active", 32'(bus.pause_active_o[0]), 1);
    chk("p_i11_clk",    32'(bus.clk_o[0]), 0);
    tick(1);
    chk("p_i12_dur",    32'(bus.pause_duration_o[7:0]), 4);
    chk("p_i12_active", 32'(bus.pause_active_o[0]), 1);
    chk("p_i12_clk",    32'(bus.clk_o[0]), 0);
    tick(1);
    chk("p_i13_active", 32'(bus.pause_active_o[0]), 0);
    chk("p_i13_clk",    32'(bus.clk_o[0]), 0);
    chk("p_i13_rise",   32'(bus.rise_o[0]), 1);
    tick(1);
    chk("p_i14_clk", 32'(bus.clk_o[0]), 1);
    chk("p_i14_dur", 32'(bus.pause_duration_o[7:0]), 4);

    // pause at level 1 while ghost already sits at 1
    bus.pause_en_i       = 4'b0001;
    bus.pause_polarity_i = 4'b0001;
    tick(1);
    chk("q_i15_active", 32'(bus.pause_active_o[0]), 1);
    chk("q_i15_clk",    32'(bus.clk_o[0]), 1);
    chk("q_i15_dur",    32'(bus.pause_duration_o[7:0]), 0);
    chk("q_i15_fall",   32'(bus.fall_o[0]), 0);
    tick(1);
    chk("q_i16_ghost", 32'(bus.ghost_clk_o[0]), 0);
    chk("q_i16_clk",   32'(bus.clk_o[0]), 1);
    chk("q_i16_dur",   32'(bus.pause_duration_o[7:0]), 1);
    bus.pause_en_i = 4'b0000;
    tick(3);
    chk("q_i19_active", 32'(bus.pause_active_o[0]), 0);
    chk("q_i19_clk",    32'(bus.clk_o[0]), 1);
    chk("q_i19_dur",    32'(bus.pause_duration_o[7:0]), 2);
    chk("q_i19_fall",   32'(bus.fall_o[0]), 1);

    // four channels, hp {4,3,2,1}, init pulse (edge J)
    bus.pause_polarity_i = 4'b0000;
    bus.half_period_i    = {8'd4, 8'd3, 8'd2, 8'd1};
    bus.ch_en_i          = 4'b1111;
    bus.init_i           = 1'b1;
    tick(1);
    bus.init_i = 1'b0;
    chk("m_j0_clk",   32'(bus.clk_o), 32'hA);
    chk("m_j0_ghost", 32'(bus.ghost_clk_o), 32'hA);
    tick(1);
    chk("m_j1_clk", 32'(bus.clk_o), 32'hB);
    tick(1);
    chk("m_j2_clk",    32'(bus.clk_o), 32'h8);
    chk("m_j2_locked", 32'(bus.locked_o), 32'h1);
    tick(1);
    chk("m_j3_clk",  32'(bus.clk_o), 32'hD);
    chk("m_j3_rise", 32'(bus.rise_o), 32'h2);
    chk("m_j3_fall", 32'(bus.fall_o), 32'h9);
    tick(1);
    chk("m_j4_clk",    32'(bus.clk_o), 32'h6);
    chk("m_j4_locked", 32'(bus.locked_o), 32'h3);

    // ch2 period 3 -> 5 mid half period
    tick(2);
    chk("h_j6_locked2", 32'(bus.locked_o[2]), 1);
    tick(1);
    bus.half_period_i[23:16] = 8'd5;
    tick(1);
    chk("h_j8_clk2", 32'(bus.clk_o[2]), 0);
    tick(1);
    chk("h_j9_clk2",    32'(bus.clk_o[2]), 1);
    chk("h_j9_locked2", 32'(bus.locked_o[2]), 0);
    tick(4);
    chk("h_j13_clk2",  32'(bus.clk_o[2]), 1);
    chk("h_j13_fall2", 32'(bus.fall_o[2]), 1);
    tick(1);
    chk("h_j14_clk2",    32'(bus.clk_o[2]), 0);
    chk("h_j14_locked2", 32'(bus.locked_o[2]), 0);
    tick(5);
    chk("h_j19_clk2",    32'(bus.clk_o[2]), 1);
    chk("h_j19_locked2", 32'(bus.locked_o[2]), 1);

    // clk_en low for ten edges
    tick(1);
    chk("e_j20_clk", 32'(bus.clk_o), 32'h6);
    bus.clk_en_i = 1'b0;
    tick(5);
    chk("e_j25_clk",  32'(bus.clk_o), 32'h6);
    chk("e_j25_rise", 32'(bus.rise_o), 0);
    chk("e_j25_fall", 32'(bus.fall_o), 0);
    tick(5);
    chk("e_j30_clk",  32'(bus.clk_o), 32'h6);
    chk("e_j30_rise", 32'(bus.rise_o), 0);
    bus.clk_en_i = 1'b1;
    tick(1);
    chk("e_j31_clk0", 32'(bus.clk_o[0]), 1);
    tick(2);
    chk("e_j33_clk2",  32'(bus.clk_o[2]), 1);
    chk("e_j33_fall2", 32'(bus.fall_o[2]), 1);
    tick(1);
    chk("e_j34_clk", 32'(bus.clk_o), 32'hA);

    // async reset in the middle of a pause
    bus.pause_en_i = 4'b0001;
    tick(1);
    chk("r_j35_active", 32'(bus.pause_active_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("r_clk",    32'(bus.clk_o), 32'hA);
    chk("r_ghost",  32'(bus.ghost_clk_o), 32'hA);
    chk("r_rise",   32'(bus.rise_o), 0);
    chk("r_fall",   32'(bus.fall_o), 0);
    chk("r_active", 32'(bus.pause_active_o), 0);
    chk("r_dur",    bus.pause_duration_o, 0);
    chk("r_locked", 32'(bus.locked_o), 0);
    tick(2);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
